pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute control sequencer: steps INIT -> FETCH -> DECODE -> EXEC, counts
// retired instructions and traps into HALT on TRAP HALT or into FAULT on a fetch timeout.
module pc_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_ready,
  input  logic [15:0] ir,
  input  logic        exec_done,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        ld_ir,
  output logic        ld_pc,
  output logic [1:0]  pc_sel,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault,
  output logic [15:0] icount
);

  typedef enum logic [2:0] {
    StInit   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StHalt   = 3'd4,
    StFault  = 3'd5
  } state_e;

  localparam logic [1:0]  PcSelInc    = 2'b00;
  localparam logic [1:0]  PcSelBranch = 2'b01;
  localparam logic [1:0]  PcSelReset  = 2'b10;
  localparam logic [15:0] TrapHalt    = 16'hF025;
  // Wait count seen in the TIMEOUT-th FETCH cycle.
  localparam logic [7:0]  WaitLast    = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] icount_q, icount_d;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    icount_d = icount_q;
    mem_req  = 1'b0;
    ld_ir    = 1'b0;
    ld_pc    = 1'b0;
    pc_sel   = PcSelInc;
    case (state_q)
      StInit: begin
        ld_pc   = 1'b1;
        pc_sel  = PcSelReset;
        state_d = StFetch;
      end
      StFetch: begin
        mem_req = 1'b1;
        // A completing read in the last allowed cycle still counts as a normal fetch.
        if (mem_ready) begin
          ld_ir   = 1'b1;
          ld_pc   = 1'b1;
          wait_d  = '0;
          state_d = StDecode;
        end else if (wait_q >= WaitLast) begin
          wait_d  = '0;
          state_d = StFault;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDecode: begin
        if (ir == TrapHalt) begin
          icount_d = icount_q + 16'd1;
          state_d  = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (exec_done) begin
          icount_d = icount_q + 16'd1;
          state_d  = StFetch;
          if (br_taken) begin
            ld_pc  = 1'b1;
            pc_sel = PcSelBranch;
          end
        end
      end
      StHalt, StFault: begin
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StInit;
      wait_q   <= '0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      icount_q <= icount_d;
    end
  end

  assign state  = state_q;
  assign halted = (state_q == StHalt);
  assign fault  = (state_q == StFault);
  assign icount = icount_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each stimulus cycle queues its expected outputs and a
// monitor pops and compares them mid-cycle.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        mem_ready;
  logic [15:0] ir;
  logic        exec_done;
  logic        br_taken;
  logic        mem_req;
  logic        ld_ir;
  logic        ld_pc;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic        halted;
  logic        fault;
  logic [15:0] icount;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic        chk;
    logic [25:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  pc_sequencer #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_ready (mem_ready),
    .ir        (ir),
    .exec_done (exec_done),
    .br_taken  (br_taken),
    .mem_req   (mem_req),
    .ld_ir     (ld_ir),
    .ld_pc     (ld_pc),
    .pc_sel    (pc_sel),
    .state     (state),
    .halted    (halted),
    .fault     (fault),
    .icount    (icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [25:0] o(input logic [2:0] st, input logic mr, input logic li,
                                    input logic lp, input logic [1:0] ps, input logic h,
                                    input logic f, input logic [15:0] ic);
    return {st, mr, li, lp, ps, h, f, ic};
  endfunction

  task automatic step(input logic rst, input logic mr, input logic [15:0] irv,
                      input logic ed, input logic bt, input logic chk,
                      input logic [25:0] e, input string nm);
    exp_t item;
    @(negedge clk);
    reset     = rst;
    mem_ready = mr;
    ir        = irv;
    exec_done = ed;
    br_taken  = bt;
    item.chk  = chk;
    item.exp  = e;
    item.name = nm;
    exp_q.push_back(item);
  endtask

  // Outputs are combinational on state and inputs: sample 2 time units after inputs change.
  always @(negedge clk) begin
    exp_t        item;
    logic [25:0] act;
    #2;
    if (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      if (item.chk) begin
        act = {state, mem_req, ld_ir, ld_pc, pc_sel, halted, fault, icount};
        total++;
        if (act !== item.exp) begin
          bad++;
          $display("FAIL %s: got st=%0d mreq=%b ldir=%b ldpc=%b psel=%b h=%b f=%b ic=%h, want st=%0d mreq=%b ldir=%b ldpc=%b psel=%b h=%b f=%b ic=%h",
                   item.name, act[25:23], act[22], act[21], act[20], act[19:18], act[17],
                   act[16], act[15:0], item.exp[25:23], item.exp[22], item.exp[21],
                   item.exp[20], item.exp[19:18], item.exp[17], item.exp[16],
                   item.exp[15:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required finished", $time);
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    ir        = 16'h0000;
    exec_done = 1'b0;
    br_taken  = 1'b0;
    step(1, 0, 16'h0000, 0, 0, 0, '0, "reset0");
    step(1, 0, 16'h0000, 0, 0, 0, '0, "reset1");

    // Basic instruction: INIT, FETCH, DECODE, EXEC, EXEC, FETCH
    step(0, 1, 16'h0000, 0, 0, 1, o(0, 0, 0, 1, 2'b10, 0, 0, 16'd0), "init_after_reset");
    step(0, 1, 16'h0000, 0, 0, 1, o(1, 1, 1, 1, 2'b00, 0, 0, 16'd0), "fetch_ready");
    step(0, 0, 16'h1234, 0, 0, 1, o(2, 0, 0, 0, 2'b00, 0, 0, 16'd0), "decode");
    step(0, 0, 16'h1234, 0, 0, 1, o(3, 0, 0, 0, 2'b00, 0, 0, 16'd0), "exec_wait");
    step(0, 0, 16'h1234, 1, 0, 1, o(3, 0, 0, 0, 2'b00, 0, 0, 16'd0), "exec_done_nobr");
    step(0, 0, 16'h0000, 0, 0, 1, o(1, 1, 0, 0, 2'b00, 0, 0, 16'd1), "fetch_wait_ic1");

    // Branch handling
    step(0, 1, 16'h0000, 0, 1, 1, o(1, 1, 1, 1, 2'b00, 0, 0, 16'd1), "fetch_ready_br_ignored");
    step(0, 0, 16'h0000, 0, 1, 1, o(2, 0, 0, 0, 2'b00, 0, 0, 16'd1), "decode_br_ignored");
    step(0, 0, 16'h0000, 0, 1, 1, o(3, 0, 0, 0, 2'b00, 0, 0, 16'd1), "exec_br_no_done");
    step(0, 0, 16'h0000, 1, 1, 1, o(3, 0, 0, 1, 2'b01, 0, 0, 16'd1), "exec_br_taken");

    // mem_ready in the TIMEOUT-th FETCH cycle wins
    for (int i = 0; i < 3; i++)
      step(0, 0, 16'h0000, 0, 0, 1, o(1, 1, 0, 0, 2'b00, 0, 0, 16'd2), "fetch_wait_pre_last");
    step(0, 1, 16'h0000, 0, 0, 1, o(1, 1, 1, 1, 2'b00, 0, 0, 16'd2), "fetch_ready_last");

    // TRAP HALT and absorbing HALT
    step(0, 0, 16'hF025, 0, 0, 1, o(2, 0, 0, 0, 2'b00, 0, 0, 16'd2), "decode_trap");
    for (int i = 0; i < 20; i++) begin
      logic mr;
      mr = i[0];
      step(0, mr, 16'hF025, 1, 1, 1, o(4, 0, 0, 0, 2'b00, 1, 0, 16'd3), "halt_hold");
    end
    step(1, 1, 16'hF025, 1, 1, 1, o(4, 0, 0, 0, 2'b00, 1, 0, 16'd3), "halt_under_reset");
    step(0, 0, 16'h0000, 0, 0, 1, o(0, 0, 0, 1, 2'b10, 0, 0, 16'd0), "init_after_halt");

    // Fetch timeout into FAULT
    for (int i = 0; i < 4; i++)
      step(0, 0, 16'h0000, 0, 0, 1, o(1, 1, 0, 0, 2'b00, 0, 0, 16'd0), "fetch_timeout");
    for (int i = 0; i < 3; i++)
      step(0, 1, 16'h0000, 1, 1, 1, o(5, 0, 0, 0, 2'b00, 0, 1, 16'd0), "fault_hold");
    step(1, 1, 16'h0000, 1, 1, 1, o(5, 0, 0, 0, 2'b00, 0, 1, 16'd0), "fault_under_reset");
    step(0, 1, 16'h0000, 0, 0, 1, o(0, 0, 0, 1, 2'b10, 0, 0, 16'd0), "init_after_fault");

    // Reset mid-EXEC beats a completing instruction
    step(0, 1, 16'h0000, 0, 0, 1, o(1, 1, 1, 1, 2'b00, 0, 0, 16'd0), "fetch_before_exec_rst");
    step(0, 0, 16'h0000, 0, 0, 1, o(2, 0, 0, 0, 2'b00, 0, 0, 16'd0), "decode_before_exec_rst");
    step(0, 0, 16'h0000, 0, 0, 1, o(3, 0, 0, 0, 2'b00, 0, 0, 16'd0), "exec_before_rst");
    step(1, 0, 16'h0000, 1, 1, 1, o(3, 0, 0, 1, 2'b01, 0, 0, 16'd0), "exec_under_reset");
    step(0, 1, 16'h0000, 0, 0, 1, o(0, 0, 0, 1, 2'b10, 0, 0, 16'd0), "init_after_exec");

    // icount wrap from 0xFFFF
    step(0, 1, 16'h0000, 0, 0, 1, o(1, 1, 1, 1, 2'b00, 0, 0, 16'd0), "wrap_fetch");
    step(0, 0, 16'h0000, 0, 0, 1, o(2, 0, 0, 0, 2'b00, 0, 0, 16'd0), "wrap_decode");
    step(0, 0, 16'h0000, 0, 0, 1, o(3, 0, 0, 0, 2'b00, 0, 0, 16'd0), "wrap_exec_wait");
    #3;
    force dut.icount_q = 16'hFFFF;
    #1;
    release dut.icount_q;
    step(0, 0, 16'h0000, 1, 0, 1, o(3, 0, 0, 0, 2'b00, 0, 0, 16'hFFFF), "exec_at_ffff");
    step(0, 0, 16'h0000, 0, 0, 1, o(1, 1, 0, 0, 2'b00, 0, 0, 16'h0000), "icount_wrapped");

    @(negedge clk);
    #4;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
